// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with write-first bypass, optional zero entry and scrub engine (define REGFILE_DUMP_EN for a per-cycle dump)
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [AW-1:0]    a1_i,
    input  logic [AW-1:0]    a2_i,
    input  logic [AW-1:0]    a3_i,
    input  logic             we3_i,
    input  logic [WIDTH-1:0] wd3_i,
    output logic [WIDTH-1:0] rd1_o,
    output logic [WIDTH-1:0] rd2_o,
    input  logic             clr_req_i,
    output logic             clr_busy_o,
    output logic             clr_done_o
);
    localparam int IW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;
    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d, i1, i2, i3;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_en, unused_hi;
    assign i1 = a1_i[IW-1:0];
    assign i2 = a2_i[IW-1:0];
    assign i3 = a3_i[IW-1:0];
    assign unused_hi = ^{a1_i, a2_i, a3_i};
    assign wr_en = we3_i && !rst_i && state_q == IDLE && !(ZERO_REG && i3 == '0);
    // scrub sequencing: idle until requested, sweep every entry, one done cycle
    always_comb begin
        state_d = state_q == IDLE ? (clr_req_i ? SWEEP : IDLE) :
                  state_q == SWEEP ? (ptr_q == IW'(DEPTH - 1) ? DONE : SWEEP) : IDLE;
        ptr_d = state_q == SWEEP ? ptr_q + IW'(1) : '0;
    end
    // array next state: the sweep clears its entry, otherwise an accepted write lands
    always_comb begin
        mem_d = mem_q;
        if (state_q == SWEEP) mem_d[ptr_q] = '0;
        else if (wr_en) mem_d[i3] = wd3_i;
    end
    // state, pointer and array registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mem_q   <= mem_d;
        end
    end
    // read ports with write-first bypass, plus scrub status
    always_comb begin
        rd1_o      = (ZERO_REG && i1 == '0) ? '0 : (wr_en && i1 == i3) ? wd3_i : mem_q[i1];
        rd2_o      = (ZERO_REG && i2 == '0) ? '0 : (wr_en && i2 == i3) ? wd3_i : mem_q[i2];
        clr_busy_o = state_q == SWEEP;
        clr_done_o = state_q == DONE;
    end
`ifdef REGFILE_DUMP_EN
    // dump the whole array on every falling edge
    always @(negedge clk_i) begin
        $display("REGISTER VALUES");
        for (int i = 0; i < DEPTH; i++) $display("register %0d %h", i, mem_q[i]);
    end
`endif
endmodule
